// File: rtl/data_mem_arbiter.sv
// CPU/host arbiter for one single-port data memory with read-return routing.
// Optional conflict counter: define DATA_MEM_ARB_PERF_EN.
module data_mem_arbiter #(
  parameter int AW       = 12,
  parameter int MAX_WAIT = 8,
  parameter int CW       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [31:0]   cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [31:0]   host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [31:0]   host_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    CPU_RD,
    HOST_RD
  } state_e;

  state_e        state_q;
  logic [CW-1:0] wait_q;
  logic [CW-1:0] wait_d;
  logic          force_gnt;

  assign force_gnt = host_req
                   && (wait_q >= CW'(MAX_WAIT));
  assign host_gnt  = host_req
                   && (force_gnt || !cpu_req);
  assign cpu_gnt   = cpu_req && !host_gnt;
  assign mem_en    = cpu_gnt || host_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      cpu_gnt: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      host_gnt: begin
        mem_we    = host_we;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
      end
      default: ;
    endcase
  end

  // Starvation counter saturates rather than wrapping.
  always_comb begin
    wait_d = wait_q;
    if (!host_req || host_gnt)
      wait_d = '0;
    else if (wait_q != '1)
      wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      wait_q <= wait_d;
      unique case (1'b1)
        cpu_gnt && !cpu_we:   state_q <= CPU_RD;
        host_gnt && !host_we: state_q <= HOST_RD;
        default:              state_q <= IDLE;
      endcase
    end
  end

  assign cpu_rvalid  = (state_q == CPU_RD);
  assign host_rvalid = (state_q == HOST_RD);
  assign cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
  assign host_rdata  = host_rvalid ? mem_rdata : '0;

`ifdef DATA_MEM_ARB_PERF_EN
  logic [31:0] conflict_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      conflict_q <= '0;
    else if (cpu_req && host_req)
      conflict_q <= conflict_q + 32'd1;
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule
